fir_coeff_ctrl: RTL and testbench

//  Coefficient scheduler in front of fir. Holds NUM_SETS coefficient sets in a local bank.
//  On a swap request it stalls the sample stream, writes the selected set into fir one tap
//  per cycle, reads every tap back to verify it, then flushes the fir pipeline with zeros.

---
 rtl/fir_ctrl_pkg.sv | 30 +++
 rtl/coeff_bank.sv | 51 +++++
 rtl/fir_coeff_ctrl.sv | 178 +++++++++++++++++
 tb/tb_fir_coeff_ctrl.sv | 294 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fir_ctrl_pkg.sv
//==============================================================================
// Module      : fir_ctrl_pkg
// Description : Shared state encoding and default widths for the fir
//               coefficient controller.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

package fir_ctrl_pkg;

   localparam int C_DATA_IN_WIDTH = 16;
   localparam int C_TAPS          = 15;
   localparam int C_TAPS_WIDTH    = 16;
   localparam int C_NUM_SETS      = 4;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_LOAD   = 2'd1,
      ST_VERIFY = 2'd2,
      ST_FLUSH  = 2'd3
   } state_t;

   // Set index width; a single-set bank still needs one index bit
   function automatic int set_width(input int num_sets);
      return (num_sets > 1) ? $clog2(num_sets) : 1;
   endfunction

endpackage

`default_nettype wire

// File: rtl/coeff_bank.sv
//==============================================================================
// Module      : coeff_bank
// Description : NUM_SETS x TAPS coefficient register file. One synchronous
//               write port, one asynchronous read port, asynchronous clear.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module coeff_bank
   import fir_ctrl_pkg::*;
#(
   parameter int NUM_SETS   = C_NUM_SETS,
   parameter int TAPS       = C_TAPS,
   parameter int TAPS_WIDTH = C_TAPS_WIDTH,
   parameter int SET_WIDTH  = set_width(C_NUM_SETS),
   parameter int ADDR_WIDTH = $clog2(C_TAPS + 1)
) (
   input  logic                  clk_i,
   input  logic                  rst_ni,
   input  logic                  wr_en_i,
   input  logic [SET_WIDTH-1:0]  wr_set_i,
   input  logic [ADDR_WIDTH-1:0] wr_addr_i,
   input  logic [TAPS_WIDTH-1:0] wr_data_i,
   input  logic [SET_WIDTH-1:0]  rd_set_i,
   input  logic [ADDR_WIDTH-1:0] rd_addr_i,
   output logic [TAPS_WIDTH-1:0] rd_data_o
);

   localparam logic [ADDR_WIDTH-1:0] C_TAPS_CNT = ADDR_WIDTH'(TAPS);

   logic [TAPS_WIDTH-1:0] r_mem [NUM_SETS][TAPS];

   // Storage: cleared on reset, one coefficient written per cycle otherwise
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         for (int s = 0; s < NUM_SETS; s++) begin
            for (int t = 0; t < TAPS; t++) begin
               r_mem[s][t] <= '0;
            end
         end
      end else if (wr_en_i) begin
         r_mem[wr_set_i][wr_addr_i] <= wr_data_i;
      end
   end

   // Out-of-range tap addresses read as zero (the verify pass probes one past the end)
   assign rd_data_o = (rd_addr_i < C_TAPS_CNT) ? r_mem[rd_set_i][rd_addr_i] : '0;

endmodule

`default_nettype wire

// File: rtl/fir_coeff_ctrl.sv
//==============================================================================
// Module      : fir_coeff_ctrl
// Description : Coefficient scheduler in front of fir. Passes samples through
//               while idle; on a swap it loads a bank set into fir, reads it
//               back for verification and flushes the fir pipeline with zeros.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module fir_coeff_ctrl
   import fir_ctrl_pkg::*;
#(
   parameter int DATA_IN_WIDTH   = C_DATA_IN_WIDTH,
   parameter int TAPS            = C_TAPS,
   parameter int TAPS_WIDTH      = C_TAPS_WIDTH,
   parameter int NUM_SETS        = C_NUM_SETS,
   parameter int TAPS_ADDR_WIDTH = $clog2(TAPS + 1),
   parameter int SET_WIDTH       = set_width(NUM_SETS)
) (
   input  logic                       clk_i,
   input  logic                       rst_ni,
   input  logic                       cfg_wr_i,
   input  logic [SET_WIDTH-1:0]       cfg_set_i,
   input  logic [TAPS_ADDR_WIDTH-1:0] cfg_addr_i,
   input  logic [TAPS_WIDTH-1:0]      cfg_data_i,
   output logic                       cfg_drop_o,
   input  logic                       swap_req_i,
   input  logic [SET_WIDTH-1:0]       swap_set_i,
   output logic                       swap_ack_o,
   output logic                       busy_o,
   output logic                       done_o,
   output logic                       verify_err_o,
   output logic [SET_WIDTH-1:0]       active_set_o,
   input  logic                       src_valid_i,
   input  logic [DATA_IN_WIDTH-1:0]   src_data_i,
   output logic                       src_ready_o,
   output logic                       fir_valid_o,
   output logic [DATA_IN_WIDTH-1:0]   fir_data_o,
   output logic                       fir_coeff_o,
   output logic [TAPS_ADDR_WIDTH-1:0] fir_addr_o,
   output logic [TAPS_WIDTH-1:0]      fir_cdata_o,
   input  logic [TAPS_WIDTH-1:0]      fir_cdata_i
);

   localparam logic [TAPS_ADDR_WIDTH-1:0] C_LAST_TAP = TAPS_ADDR_WIDTH'(TAPS - 1);
   localparam logic [TAPS_ADDR_WIDTH-1:0] C_TAPS_CNT = TAPS_ADDR_WIDTH'(TAPS);

   state_t                       r_state;
   state_t                       w_state_nxt;
   logic [TAPS_ADDR_WIDTH-1:0]   r_cnt;
   logic [SET_WIDTH-1:0]         r_set;
   logic                         r_verr;
   logic [SET_WIDTH-1:0]         r_active;
   logic [TAPS_ADDR_WIDTH-1:0]   w_rd_addr;
   logic [TAPS_WIDTH-1:0]        w_rd_data;
   logic                         w_cmp_en;
   logic                         w_accept;
   logic                         w_addr_bad;
   logic                         w_set_bad;
   logic                         w_set_locked;
   logic                         w_cfg_we;

   // Config write filter: out-of-range targets and the set being loaded are refused
   assign w_addr_bad   = (cfg_addr_i >= C_TAPS_CNT);
   assign w_set_locked = busy_o && (cfg_set_i == r_set);
   assign cfg_drop_o   = cfg_wr_i && (w_addr_bad || w_set_bad || w_set_locked);
   assign w_cfg_we     = cfg_wr_i && !cfg_drop_o;

   generate
      if (NUM_SETS == (1 << SET_WIDTH)) begin : g_set_full
         assign w_set_bad = 1'b0;
      end else begin : g_set_partial
         assign w_set_bad = (cfg_set_i >= SET_WIDTH'(NUM_SETS));
      end
   endgenerate

   coeff_bank #(
      .NUM_SETS   (NUM_SETS),
      .TAPS       (TAPS),
      .TAPS_WIDTH (TAPS_WIDTH),
      .SET_WIDTH  (SET_WIDTH),
      .ADDR_WIDTH (TAPS_ADDR_WIDTH)
   ) u_bank (
      .clk_i     (clk_i),
      .rst_ni    (rst_ni),
      .wr_en_i   (w_cfg_we),
      .wr_set_i  (cfg_set_i),
      .wr_addr_i (cfg_addr_i),
      .wr_data_i (cfg_data_i),
      .rd_set_i  (r_set),
      .rd_addr_i (w_rd_addr),
      .rd_data_o (w_rd_data)
   );

   assign w_accept     = (r_state == ST_IDLE) && swap_req_i;
   assign verify_err_o = r_verr;
   assign active_set_o = r_active;
   assign fir_cdata_o  = fir_coeff_o ? w_rd_data : '0;

   // State register
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // Next state and fir-side muxing; readback arrives one cycle after its address
   always_comb begin
      w_state_nxt = r_state;
      swap_ack_o  = 1'b0;
      src_ready_o = 1'b0;
      busy_o      = 1'b1;
      done_o      = 1'b0;
      fir_valid_o = 1'b0;
      fir_data_o  = '0;
      fir_coeff_o = 1'b0;
      fir_addr_o  = '0;
      w_rd_addr   = r_cnt;
      w_cmp_en    = 1'b0;
      case (r_state)
         ST_IDLE: begin
            swap_ack_o  = 1'b1;
            src_ready_o = 1'b1;
            busy_o      = 1'b0;
            fir_valid_o = src_valid_i;
            fir_data_o  = src_data_i;
            if (swap_req_i) w_state_nxt = ST_LOAD;
         end
         ST_LOAD: begin
            fir_coeff_o = 1'b1;
            fir_addr_o  = r_cnt;
            if (r_cnt == C_LAST_TAP) w_state_nxt = ST_VERIFY;
         end
         ST_VERIFY: begin
            if (r_cnt != C_TAPS_CNT) fir_addr_o = r_cnt;
            w_rd_addr = r_cnt - 1'b1;
            w_cmp_en  = (r_cnt != '0);
            if (r_cnt == C_TAPS_CNT) w_state_nxt = ST_FLUSH;
         end
         ST_FLUSH: begin
            fir_valid_o = 1'b1;
            if (r_cnt == C_TAPS_CNT) begin
               done_o      = 1'b1;
               w_state_nxt = ST_IDLE;
            end
         end
         default: w_state_nxt = ST_IDLE;
      endcase
   end

   // Phase counter, latched set, sticky verify flag and committed set
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         r_cnt    <= '0;
         r_set    <= '0;
         r_verr   <= 1'b0;
         r_active <= '0;
      end else begin
         if (r_state != w_state_nxt) begin
            r_cnt <= '0;
         end else if (r_state != ST_IDLE) begin
            r_cnt <= r_cnt + 1'b1;
         end
         if (w_accept) begin
            r_set  <= swap_set_i;
            r_verr <= 1'b0;
         end else if (w_cmp_en && (fir_cdata_i != w_rd_data)) begin
            r_verr <= 1'b1;
         end
         if (done_o) r_active <= r_set;
      end
   end

endmodule

`default_nettype wire

// File: tb/tb_fir_coeff_ctrl.sv
//==============================================================================
// Module      : tb_fir_coeff_ctrl
// Description : Scoreboard bench for fir_coeff_ctrl with a behavioural fir
//               tap memory and a reference coefficient bank.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module tb_fir_coeff_ctrl;

   localparam int TAPS = 15;
   localparam int NS   = 4;
   localparam int LAT  = 3 * TAPS + 2;

   logic        clk_i = 1'b0;
   logic        rst_ni = 1'b0;
   logic        cfg_wr_i = 1'b0;
   logic [1:0]  cfg_set_i = '0;
   logic [3:0]  cfg_addr_i = '0;
   logic [15:0] cfg_data_i = '0;
   logic        cfg_drop_o;
   logic        swap_req_i = 1'b0;
   logic [1:0]  swap_set_i = '0;
   logic        swap_ack_o, busy_o, done_o, verify_err_o;
   logic [1:0]  active_set_o;
   logic        src_valid_i = 1'b0;
   logic [15:0] src_data_i = '0;
   logic        src_ready_o, fir_valid_o, fir_coeff_o;
   logic [15:0] fir_data_o;
   logic [3:0]  fir_addr_o;
   logic [15:0] fir_cdata_o;
   logic [15:0] fir_cdata_i;

   fir_coeff_ctrl dut (
      .clk_i        (clk_i),
      .rst_ni       (rst_ni),
      .cfg_wr_i     (cfg_wr_i),
      .cfg_set_i    (cfg_set_i),
      .cfg_addr_i   (cfg_addr_i),
      .cfg_data_i   (cfg_data_i),
      .cfg_drop_o   (cfg_drop_o),
      .swap_req_i   (swap_req_i),
      .swap_set_i   (swap_set_i),
      .swap_ack_o   (swap_ack_o),
      .busy_o       (busy_o),
      .done_o       (done_o),
      .verify_err_o (verify_err_o),
      .active_set_o (active_set_o),
      .src_valid_i  (src_valid_i),
      .src_data_i   (src_data_i),
      .src_ready_o  (src_ready_o),
      .fir_valid_o  (fir_valid_o),
      .fir_data_o   (fir_data_o),
      .fir_coeff_o  (fir_coeff_o),
      .fir_addr_o   (fir_addr_o),
      .fir_cdata_o  (fir_cdata_o),
      .fir_cdata_i  (fir_cdata_i)
   );

   always #5 clk_i = ~clk_i;

   int n_vec = 0;
   int n_err = 0;
   int cyc   = 0;

   // Reference state
   logic [15:0] ref_bank [NS][TAPS];
   logic [15:0] fir_taps [TAPS];
   logic [15:0] rb = '0;
   bit          swapping = 0;
   bit          corrupt  = 0;
   int          cur_set  = 0;
   int          flush_cnt = 0;

   typedef struct { int addr; int data; } cw_t;
   typedef struct { int cyc; int set; bit verr; } dn_t;
   logic [15:0] q_samp [$];
   cw_t         q_cw   [$];
   dn_t         q_done [$];

   assign fir_cdata_i = rb;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
      end
   endtask

   always @(posedge clk_i) cyc <= cyc + 1;

   // Behavioural fir tap memory: writes on coeff strobe, registered readback
   always @(posedge clk_i) begin
      if (fir_coeff_o && fir_addr_o < 4'(TAPS)) fir_taps[fir_addr_o] <= fir_cdata_o;
      rb <= ((fir_addr_o < 4'(TAPS)) ? fir_taps[fir_addr_o] : 16'h0)
            ^ ((corrupt && fir_addr_o == 4'd7) ? 16'h0080 : 16'h0);
   end

   // Monitor: pops expectations whenever the DUT presents an output event
   always @(negedge clk_i) begin : mon
      logic [15:0] s;
      cw_t e;
      dn_t d;
      if (rst_ni) begin
         if (fir_valid_o && src_ready_o) begin
            if (q_samp.size() == 0) chk("stray_sample", 1, 0);
            else begin s = q_samp.pop_front(); chk("passthru", fir_data_o, s); end
         end
         if (fir_valid_o && !src_ready_o) begin
            flush_cnt++;
            chk("flush_zero", fir_data_o, 0);
         end
         if (fir_coeff_o) begin
            if (q_cw.size() == 0) chk("stray_coeff", 1, 0);
            else begin
               e = q_cw.pop_front();
               chk("coeff_addr", fir_addr_o, e.addr);
               chk("coeff_data", fir_cdata_o, e.data);
            end
         end
         if (done_o) begin
            if (q_done.size() == 0) chk("stray_done", 1, 0);
            else begin
               d = q_done.pop_front();
               chk("done_cycle", cyc, d.cyc);
               chk("verify_err", verify_err_o, d.verr);
               chk("flush_beats", flush_cnt, TAPS + 1);
            end
            swapping = 0;
         end
      end
   end

   task automatic tick();
      @(posedge clk_i); #1;
   endtask

   function automatic bit drop_exp(input int s, input int a);
      return (a >= TAPS) || (s >= NS) || (swapping && s == cur_set);
   endfunction

   task automatic sample(input logic [15:0] d);
      src_valid_i = 1'b1; src_data_i = d;
      q_samp.push_back(d);
      tick();
      src_valid_i = 1'b0;
   endtask

   task automatic cfg_write(input int s, input int a, input int d);
      bit e;
      e = drop_exp(s, a);
      cfg_wr_i = 1'b1; cfg_set_i = 2'(s); cfg_addr_i = 4'(a); cfg_data_i = 16'(d);
      if (!e) ref_bank[s][a] = 16'(d);
      @(negedge clk_i);
      chk("cfg_drop", cfg_drop_o, e);
      tick();
      cfg_wr_i = 1'b0;
   endtask

   task automatic start_swap(input int s, input bit wr, input int wa, input int wd, input bit bad);
      bit e;
      e = 0;
      swap_req_i = 1'b1; swap_set_i = 2'(s);
      if (wr) begin
         e = drop_exp(s, wa);
         cfg_wr_i = 1'b1; cfg_set_i = 2'(s); cfg_addr_i = 4'(wa); cfg_data_i = 16'(wd);
         if (!e) ref_bank[s][wa] = 16'(wd);
      end
      for (int k = 0; k < TAPS; k++) q_cw.push_back('{k, int'(ref_bank[s][k])});
      q_done.push_back('{cyc + LAT, s, bad});
      cur_set = s; flush_cnt = 0;
      @(negedge clk_i);
      chk("swap_ack", swap_ack_o, 1);
      if (wr) chk("cfg_drop_acc", cfg_drop_o, e);
      swapping = 1;
      tick();
      swap_req_i = 1'b0; cfg_wr_i = 1'b0;
   endtask

   task automatic wait_done(input int s);
      for (int i = 0; i < 200 && swapping; i++) @(posedge clk_i);
      if (swapping) begin chk("done_timeout", 1, 0); swapping = 0; end
      #1;
      chk("active_set", active_set_o, s);
      for (int k = 0; k < TAPS; k++) chk("fir_tap", fir_taps[k], ref_bank[s][k]);
   endtask

   initial begin
      for (int s = 0; s < NS; s++) for (int t = 0; t < TAPS; t++) ref_bank[s][t] = '0;
      for (int t = 0; t < TAPS; t++) fir_taps[t] = '0;

      // Reset state
      repeat (2) @(negedge clk_i);
      chk("rst_ack", swap_ack_o, 1);
      chk("rst_ready", src_ready_o, 1);
      chk("rst_busy", busy_o, 0);
      chk("rst_done", done_o, 0);
      chk("rst_verr", verify_err_o, 0);
      chk("rst_active", active_set_o, 0);
      chk("rst_coeff", fir_coeff_o, 0);
      chk("rst_fvalid", fir_valid_o, 0);
      chk("rst_drop", cfg_drop_o, 0);
      @(posedge clk_i); #1 rst_ni = 1'b1;
      tick();

      // Pass-through stream
      sample(16'd1); sample(16'd2); sample(16'd3);
      for (int i = 0; i < 8; i++) sample(16'($urandom));

      // Bank fill: set1 = 1..15, others random, plus an out-of-range tap
      for (int k = 0; k < TAPS; k++) cfg_write(1, k, k + 1);
      for (int s = 0; s < NS; s++)
         if (s != 1) for (int k = 0; k < TAPS; k++) cfg_write(s, k, int'($urandom_range(0, 65535)));
      cfg_write(0, 15, 16'hDEAD);

      // Swap set1
      start_swap(1, 0, 0, 0, 0);
      wait_done(1);

      // Impulse through the freshly loaded fir
      sample(16'd1);
      for (int i = 0; i < 14; i++) sample(16'd0);

      // Corrupted readback of tap 7 -> sticky verify error
      corrupt = 1;
      start_swap(0, 0, 0, 0, 1);
      wait_done(0);
      corrupt = 0;
      repeat (3) tick();
      chk("verr_sticky", verify_err_o, 1);

      // Swap set2 with same-cycle write, locked write, other-set write, ignored requests
      start_swap(2, 1, 3, 16'hABCD, 0);
      cfg_write(2, 4, 16'h1111);
      cfg_write(3, 0, 16'h2222);
      swap_req_i = 1'b1; swap_set_i = 2'd3; src_valid_i = 1'b1; src_data_i = 16'h0055;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk_i);
         chk("busy_ready", src_ready_o, 0);
         chk("busy_ack", swap_ack_o, 0);
         chk("busy_fvalid", fir_valid_o, 0);
         tick();
      end
      swap_req_i = 1'b0; src_valid_i = 1'b0;
      wait_done(2);

      start_swap(3, 0, 0, 0, 0);
      wait_done(3);

      // Reset during LOAD tap 5
      start_swap(2, 0, 0, 0, 0);
      repeat (5) tick();
      rst_ni = 1'b0;
      q_cw.delete(); q_done.delete(); swapping = 0;
      for (int s = 0; s < NS; s++) for (int t = 0; t < TAPS; t++) ref_bank[s][t] = '0;
      @(negedge clk_i);
      chk("mid_rst_coeff", fir_coeff_o, 0);
      chk("mid_rst_busy", busy_o, 0);
      chk("mid_rst_ack", swap_ack_o, 1);
      chk("mid_rst_active", active_set_o, 0);
      chk("mid_rst_fvalid", fir_valid_o, 0);
      tick();
      rst_ni = 1'b1;
      tick();
      for (int k = 0; k < TAPS; k++) cfg_write(1, k, int'($urandom_range(0, 65535)));
      start_swap(1, 0, 0, 0, 0);
      wait_done(1);

      // Randomised traffic
      for (int it = 0; it < 6; it++) begin
         int s;
         for (int i = 0; i < 6; i++)
            cfg_write(int'($urandom_range(0, NS - 1)), int'($urandom_range(0, TAPS)),
                      int'($urandom_range(0, 65535)));
         for (int i = 0; i < 4; i++) sample(16'($urandom));
         s = int'($urandom_range(0, NS - 1));
         start_swap(s, 1'($urandom_range(0, 1)), int'($urandom_range(0, TAPS - 1)),
                    int'($urandom_range(0, 65535)), 0);
         for (int i = 0; i < 4; i++)
            cfg_write(int'($urandom_range(0, NS - 1)), int'($urandom_range(0, TAPS - 1)),
                      int'($urandom_range(0, 65535)));
         wait_done(s);
      end

      repeat (2) tick();
      chk("queues_empty", 32'(q_samp.size() + q_cw.size() + q_done.size()), 0);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

`default_nettype wire
